// File: rtl/cmp_pkg.sv
// Shared types for the serial word comparator: FSM states and one-hot {e,g,l} verdict codes.
package cmp_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        DONE    = 1'b1
    } cmp_state_t;

    typedef logic [2:0] cmp_res_t;

    localparam cmp_res_t CMP_EQ   = 3'b100;
    localparam cmp_res_t CMP_GT   = 3'b010;
    localparam cmp_res_t CMP_LT   = 3'b001;
    localparam cmp_res_t CMP_NONE = 3'b000;

    function automatic logic cmp_is_onehot(input logic [2:0] code);
        return (code == CMP_EQ) || (code == CMP_GT) || (code == CMP_LT);
    endfunction

endpackage

// File: rtl/cmp_digit_decode.sv
// Maps one digit's {e,g,l} from the 2-bit comparator to a clean verdict (g > l > e priority).
// The illegal-code flag exists only when CMP_ONEHOT_CHECK_EN is defined.
module cmp_digit_decode
    import cmp_pkg::*;
(
    input  logic     i_e,
    input  logic     i_g,
    input  logic     i_l,
`ifdef CMP_ONEHOT_CHECK_EN
    output logic     o_illegal,
`endif
    output cmp_res_t o_res
);

    always_comb begin
        o_res = CMP_EQ;
        casez ({i_e, i_g, i_l})
            3'b?1?:  o_res = CMP_GT;
            3'b?01:  o_res = CMP_LT;
            default: o_res = CMP_EQ;
        endcase
    end

`ifdef CMP_ONEHOT_CHECK_EN
    assign o_illegal = !cmp_is_onehot({i_e, i_g, i_l});
`endif

endmodule

// File: rtl/cmp_serial_acc.sv
// Folds a MSB-first stream of per-digit comparator verdicts into one word verdict on a valid/ready port.
// Optional per-word one-hot checking of the digit codes is enabled by CMP_ONEHOT_CHECK_EN.
module cmp_serial_acc
    import cmp_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    output logic in_ready,
    input  logic e_in,
    input  logic g_in,
    input  logic l_in,
    output logic out_valid,
    input  logic out_ready,
    output logic e,
    output logic g,
    output logic l,
    output logic err
);

    localparam int             CW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0]  LAST = CW'(DIGITS - 1);

    cmp_state_t    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_decided;
    cmp_res_t      r_res;

    logic          w_accept;
    logic          w_first;
    cmp_res_t      w_dig_res;
    cmp_res_t      w_res_nxt;
    logic          w_decided_nxt;

`ifdef CMP_ONEHOT_CHECK_EN
    logic          w_illegal;
    logic          r_err;
`endif

    cmp_digit_decode u_decode (
        .i_e       (e_in),
        .i_g       (g_in),
        .i_l       (l_in),
`ifdef CMP_ONEHOT_CHECK_EN
        .o_illegal (w_illegal),
`endif
        .o_res     (w_dig_res)
    );

    assign in_ready  = (r_state == COLLECT);
    assign out_valid = (r_state == DONE);
    assign w_accept  = in_valid & in_ready;
    assign w_first   = (r_cnt == '0);

    // The first beat of a word starts from a clean EQ/undecided state, so no
    // residue of the previous word can leak into the new verdict.
    always_comb begin
        w_decided_nxt = w_first ? 1'b0 : r_decided;
        w_res_nxt     = w_first ? CMP_EQ : r_res;
        if (!w_decided_nxt && (w_dig_res != CMP_EQ)) begin
            w_res_nxt     = w_dig_res;
            w_decided_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= COLLECT;
            r_cnt     <= '0;
            r_decided <= 1'b0;
            r_res     <= CMP_NONE;
        end else begin
            case (r_state)
                COLLECT: begin
                    if (w_accept) begin
                        r_res     <= w_res_nxt;
                        r_decided <= w_decided_nxt;
                        if (r_cnt == LAST) begin
                            r_cnt   <= '0;
                            r_state <= DONE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= COLLECT;
                    end
                end
            endcase
        end
    end

    assign e = r_res[2];
    assign g = r_res[1];
    assign l = r_res[0];

`ifdef CMP_ONEHOT_CHECK_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= (w_first ? 1'b0 : r_err) | w_illegal;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cmp_serial_acc.sv
// Directed bench for cmp_serial_acc: a DIGITS=4 instance for word tests and a DIGITS=1 instance for single-digit words.
module tb_cmp_serial_acc;

    localparam logic [2:0] EQ  = 3'b100;
    localparam logic [2:0] GT  = 3'b010;
    localparam logic [2:0] LT  = 3'b001;
    localparam logic [2:0] BAD = 3'b110;

`ifdef CMP_ONEHOT_CHECK_EN
    localparam logic EXP_BAD_ERR = 1'b1;
`else
    localparam logic EXP_BAD_ERR = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic in_valid, in_ready, e_in, g_in, l_in, out_valid, out_ready, e, g, l, err;
    logic s_in_valid, s_in_ready, s_e_in, s_g_in, s_l_in, s_out_valid, s_out_ready;
    logic s_e, s_g, s_l, s_err;

    int n_chk  = 0;
    int n_pass = 0;

    cmp_serial_acc #(.DIGITS(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .e_in      (e_in),
        .g_in      (g_in),
        .l_in      (l_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .e         (e),
        .g         (g),
        .l         (l),
        .err       (err)
    );

    cmp_serial_acc #(.DIGITS(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .e_in      (s_e_in),
        .g_in      (s_g_in),
        .l_in      (s_l_in),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .e         (s_e),
        .g         (s_g),
        .l         (s_l),
        .err       (s_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [11:0] w);
        for (int i = 0; i < 4; i++) begin
            {e_in, g_in, l_in} = w[11-3*i -: 3];
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic chk_verdict(input string tag, input logic [2:0] egl, input logic exp_err);
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".egl"},   32'({e, g, l}), 32'(egl));
        chk({tag, ".err"},   32'(err), 32'(exp_err));
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".in_ready"},  32'(in_ready), 32'd1);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".egl"},       32'({e, g, l}), 32'd0);
        chk({tag, ".err"},       32'(err), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; {e_in, g_in, l_in} = 3'b000; out_ready = 1'b1;
        s_in_valid = 1'b0; {s_e_in, s_g_in, s_l_in} = 3'b000; s_out_ready = 1'b1;
        step();
        step();
        chk_reset_state("rst");
        chk("rst1.out_valid", 32'(s_out_valid), 32'd0);
        chk("rst1.in_ready",  32'(s_in_ready), 32'd1);
        rst_n = 1'b1;

        // a=10_01_11_00 vs b=10_00_11_01: EQ,GT,EQ,LT -> GT
        send_word({EQ, GT, EQ, LT});
        chk_verdict("w1", GT, 1'b0);
        chk("w1.in_ready", 32'(in_ready), 32'd0);
        step();
        chk("w1.pulse", 32'(out_valid), 32'd0);
        chk("w1.ready_again", 32'(in_ready), 32'd1);

        send_word({EQ, EQ, EQ, EQ});
        chk_verdict("alleq", EQ, 1'b0);
        step();
        send_word({LT, GT, GT, GT});
        chk_verdict("ltfirst", LT, 1'b0);
        step();

        // Backpressure: verdict held while in_valid stays asserted
        out_ready = 1'b0;
        send_word({GT, EQ, EQ, EQ});
        in_valid = 1'b1;
        {e_in, g_in, l_in} = LT;
        for (int i = 0; i < 5; i++) begin
            chk("hold.valid", 32'(out_valid), 32'd1);
            chk("hold.egl", 32'({e, g, l}), 32'(GT));
            chk("hold.in_ready", 32'(in_ready), 32'd0);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        chk("hold.release", 32'(out_valid), 32'd0);
        send_word({EQ, EQ, EQ, EQ});
        chk_verdict("after_hold", EQ, 1'b0);
        step();

        // Reset in the middle of a word
        for (int i = 0; i < 2; i++) begin
            {e_in, g_in, l_in} = (i == 0) ? GT : EQ;
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        step();
        chk_reset_state("midrst");
        rst_n = 1'b1;
        send_word({EQ, EQ, EQ, LT});
        chk_verdict("postrst", LT, 1'b0);
        step();

        // Non-one-hot digit code
        send_word({EQ, BAD, EQ, EQ});
        chk_verdict("bad", GT, EXP_BAD_ERR);
        step();
        send_word({EQ, EQ, EQ, EQ});
        chk_verdict("clean", EQ, 1'b0);
        step();

        // DIGITS=1: back-to-back beats, one verdict every 2 cycles
        s_in_valid = 1'b1;
        {s_e_in, s_g_in, s_l_in} = GT;
        step();
        chk("d1.gt.valid", 32'(s_out_valid), 32'd1);
        chk("d1.gt.egl", 32'({s_e, s_g, s_l}), 32'(GT));
        {s_e_in, s_g_in, s_l_in} = LT;
        step();
        chk("d1.gap1", 32'(s_out_valid), 32'd0);
        chk("d1.gap1.ready", 32'(s_in_ready), 32'd1);
        step();
        chk("d1.lt.valid", 32'(s_out_valid), 32'd1);
        chk("d1.lt.egl", 32'({s_e, s_g, s_l}), 32'(LT));
        {s_e_in, s_g_in, s_l_in} = EQ;
        step();
        chk("d1.gap2", 32'(s_out_valid), 32'd0);
        step();
        chk("d1.eq.valid", 32'(s_out_valid), 32'd1);
        chk("d1.eq.egl", 32'({s_e, s_g, s_l}), 32'(EQ));
        chk("d1.err", 32'(s_err), 32'd0);
        s_in_valid = 1'b0;
        step();
        chk("d1.idle", 32'(s_out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
